uart_tx_scheduler: RTL and testbench

- Shares the UART transmit path between two byte-stream requesters: port 0 is the debug module, port 1 is the user passthrough.
- Sequences every write into the UART interface (WE/DSEND) and emits in-band channel-switch escape sequences.
- Byte-stuffs payload bytes that equal the escape code.
- Sits between the requesters and the UART interface top; drives its write strobe and data from the UART's TX-ready flag.

---
 rtl/uart_tx_scheduler.sv | 158 +++++++++++++++
 tb/tb_uart_tx_scheduler.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_scheduler.sv
// Shares the UART transmit path between the debug port (0) and the user passthrough (1),
// inserting ESC/channel switch sequences and stuffing payload bytes equal to ESC_CODE.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | no grant held, waiting for any requester
// ARB      | one cycle: pick requester, reset burst count
// SEND_ESC | emit ESC_CODE prefix of a channel switch
// SEND_CH  | emit channel number, line channel switches with the pulse
// DATA     | forward granted requester bytes until LAST or burst limit
// STUFF    | emit second ESC_CODE after a payload byte equal to ESC_CODE
module uart_tx_scheduler #(
    parameter logic [7:0] ESC_CODE  = 8'hB1,
    parameter int         MAX_BURST = 16,
    parameter int         HOLDOFF   = 2
) (
    input  logic       CLK_I,
    input  logic       RST_NI,
    input  logic       VALID0_I,
    input  logic [7:0] DATA0_I,
    input  logic       LAST0_I,
    output logic       READY0_O,
    input  logic       VALID1_I,
    input  logic [7:0] DATA1_I,
    input  logic       LAST1_I,
    output logic       READY1_O,
    input  logic       TX_READY_I,
    output logic       WE_O,
    output logic [7:0] DSEND_O,
    output logic       CHANNEL_O,
    output logic       BUSY_O
);

    localparam int              HW         = $clog2(HOLDOFF + 1);
    localparam logic [HW-1:0]   HOLDOFF_LD = HW'(HOLDOFF);
    localparam logic [7:0]      BURST_MAX  = 8'(MAX_BURST);

    typedef enum logic [2:0] {
        S_IDLE, S_ARB, S_SEND_ESC, S_SEND_CH, S_DATA, S_STUFF
    } state_t;

    state_t          state_q, state_d;
    logic            we_q, we_d;
    logic [7:0]      dsend_q, dsend_d;
    logic            channel_q, channel_d;
    logic            grant_q, grant_d;
    logic            rr_last_q, rr_last_d;
    logic [7:0]      burst_q, burst_d;
    logic [HW-1:0]   holdoff_q, holdoff_d;
    logic            last_q, last_d;

    logic            tx_free;
    logic            valid_g, last_g, accept, arb_grant;
    logic [7:0]      data_g, burst_inc;

    assign tx_free   = TX_READY_I && (holdoff_q == '0);
    assign valid_g   = grant_q ? VALID1_I : VALID0_I;
    assign data_g    = grant_q ? DATA1_I  : DATA0_I;
    assign last_g    = grant_q ? LAST1_I  : LAST0_I;
    assign accept    = (state_q == S_DATA) && valid_g && tx_free;
    assign burst_inc = burst_q + 8'd1;
    // On contention the port that did not win last time takes the grant.
    assign arb_grant = (VALID0_I && VALID1_I) ? ~rr_last_q : VALID1_I;

    assign READY0_O  = accept && !grant_q;
    assign READY1_O  = accept && grant_q;
    assign WE_O      = we_q;
    assign DSEND_O   = dsend_q;
    assign CHANNEL_O = channel_q;
    assign BUSY_O    = (state_q != S_IDLE);

    always_comb begin
        state_d   = state_q;
        we_d      = 1'b0;
        dsend_d   = dsend_q;
        channel_d = channel_q;
        grant_d   = grant_q;
        rr_last_d = rr_last_q;
        burst_d   = burst_q;
        last_d    = last_q;
        holdoff_d = (holdoff_q != '0) ? holdoff_q - 1'b1 : '0;
        case (state_q)
            S_IDLE: begin
                if (VALID0_I || VALID1_I) state_d = S_ARB;
            end
            S_ARB: begin
                if (!(VALID0_I || VALID1_I)) begin
                    state_d = S_IDLE;
                end else begin
                    grant_d   = arb_grant;
                    rr_last_d = arb_grant;
                    burst_d   = 8'd0;
                    state_d   = (arb_grant != channel_q) ? S_SEND_ESC : S_DATA;
                end
            end
            S_SEND_ESC: begin
                if (tx_free) begin
                    we_d    = 1'b1;
                    dsend_d = ESC_CODE;
                    state_d = S_SEND_CH;
                end
            end
            S_SEND_CH: begin
                if (tx_free) begin
                    we_d      = 1'b1;
                    dsend_d   = {7'b0, grant_q};
                    channel_d = grant_q;
                    state_d   = S_DATA;
                end
            end
            S_DATA: begin
                if (accept) begin
                    we_d    = 1'b1;
                    dsend_d = data_g;
                    burst_d = burst_inc;
                    last_d  = last_g;
                    if (data_g == ESC_CODE)                     state_d = S_STUFF;
                    else if (last_g || burst_inc == BURST_MAX)  state_d = S_IDLE;
                end
            end
            S_STUFF: begin
                if (tx_free) begin
                    we_d    = 1'b1;
                    dsend_d = ESC_CODE;
                    state_d = (last_q || burst_q == BURST_MAX) ? S_IDLE : S_DATA;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // The UART's ready flag lags the strobe, so ignore it briefly after every write.
        if (we_d) holdoff_d = HOLDOFF_LD;
    end

    always_ff @(posedge CLK_I or negedge RST_NI) begin
        if (!RST_NI) begin
            state_q   <= S_IDLE;
            we_q      <= 1'b0;
            dsend_q   <= 8'd0;
            channel_q <= 1'b0;
            grant_q   <= 1'b0;
            rr_last_q <= 1'b1;
            burst_q   <= 8'd0;
            holdoff_q <= '0;
            last_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            we_q      <= we_d;
            dsend_q   <= dsend_d;
            channel_q <= channel_d;
            grant_q   <= grant_d;
            rr_last_q <= rr_last_d;
            burst_q   <= burst_d;
            holdoff_q <= holdoff_d;
            last_q    <= last_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler: logs every line write and compares against
// hand-built byte sequences (MAX_BURST=2, HOLDOFF=2).
module tb_uart_tx_scheduler;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       valid0 = 1'b0, last0 = 1'b0, valid1 = 1'b0, last1 = 1'b0;
    logic [7:0] data0 = 8'd0, data1 = 8'd0;
    logic       ready0, ready1;
    logic       tx_ready = 1'b1;
    logic       we;
    logic [7:0] dsend;
    logic       channel, busy;

    uart_tx_scheduler #(.ESC_CODE(8'hB1), .MAX_BURST(2), .HOLDOFF(2)) dut (
        .CLK_I(clk), .RST_NI(rst_n),
        .VALID0_I(valid0), .DATA0_I(data0), .LAST0_I(last0), .READY0_O(ready0),
        .VALID1_I(valid1), .DATA1_I(data1), .LAST1_I(last1), .READY1_O(ready1),
        .TX_READY_I(tx_ready), .WE_O(we), .DSEND_O(dsend),
        .CHANNEL_O(channel), .BUSY_O(busy)
    );

    always #5 clk = ~clk;

    int         n_cmp = 0, n_err = 0;
    int         cyc = 0;
    logic [7:0] line_q[$];
    logic       ch_q[$];
    int         we_cyc_q[$];
    int         rd0_cnt = 0, rd1_cnt = 0, both_rd = 0, bad_we = 0, bad_rd = 0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (we) begin
            line_q.push_back(dsend);
            ch_q.push_back(channel);
            we_cyc_q.push_back(cyc);
        end
        if (ready0) rd0_cnt++;
        if (ready1) rd1_cnt++;
        if (ready0 && ready1) both_rd++;
        if (!tx_ready && we) bad_we++;
        if (!tx_ready && (ready0 || ready1)) bad_rd++;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_line(input string tag, input int base, input logic [7:0] exp[$]);
        check_val({tag, " length"}, 32'(line_q.size() - base), 32'(exp.size()));
        for (int i = 0; i < exp.size(); i++)
            if (base + i < line_q.size())
                check_val($sformatf("%s byte%0d", tag, i), 32'(line_q[base + i]), 32'(exp[i]));
    endtask

    task automatic send_pkt(input int port, input logic [7:0] pkt[$]);
        for (int i = 0; i < pkt.size(); i++) begin
            int k;
            if (port == 0) begin valid0 = 1'b1; data0 = pkt[i]; last0 = (i == pkt.size() - 1); end
            else           begin valid1 = 1'b1; data1 = pkt[i]; last1 = (i == pkt.size() - 1); end
            for (k = 0; k < 400; k++) begin
                @(negedge clk);
                if ((port == 0) ? ready0 : ready1) break;
            end
            if (k == 400) check_val($sformatf("ready timeout port%0d", port), 32'd0, 32'd1);
            @(posedge clk); #1;
        end
        if (port == 0) begin valid0 = 1'b0; last0 = 1'b0; end
        else           begin valid1 = 1'b0; last1 = 1'b0; end
    endtask

    task automatic idle_wait(input string tag);
        int k;
        for (k = 0; k < 300; k++) begin
            @(negedge clk);
            if (!busy) break;
        end
        repeat (6) @(negedge clk);
        check_val({tag, " busy idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        logic [7:0] e[$];
        logic [7:0] p0[$];
        logic [7:0] p1[$];
        int         base, rise_cyc;

        #23;
        check_val("rst we", 32'(we), 32'd0);
        check_val("rst dsend", 32'(dsend), 32'd0);
        check_val("rst channel", 32'(channel), 32'd0);
        check_val("rst busy", 32'(busy), 32'd0);
        check_val("rst ready", 32'({ready0, ready1}), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // single byte on the already-selected channel: no escape
        base = line_q.size(); rd0_cnt = 0;
        p0 = '{8'h41}; send_pkt(0, p0); idle_wait("t1");
        e = '{8'h41}; check_line("t1", base, e);
        check_val("t1 ready0 count", 32'(rd0_cnt), 32'd1);

        // channel switch to port 1
        base = line_q.size(); rd1_cnt = 0;
        p1 = '{8'h10, 8'h20}; send_pkt(1, p1); idle_wait("t2");
        e = '{8'hB1, 8'h01, 8'h10, 8'h20}; check_line("t2", base, e);
        check_val("t2 ready1 count", 32'(rd1_cnt), 32'd2);
        if (ch_q.size() >= base + 4) begin
            check_val("t2 ch at esc", 32'(ch_q[base]), 32'd0);
            check_val("t2 ch at 01", 32'(ch_q[base + 1]), 32'd1);
            check_val("t2 ch at data", 32'(ch_q[base + 3]), 32'd1);
            check_val("t2 holdoff gap", 32'(we_cyc_q[base + 1] - we_cyc_q[base]), 32'd3);
        end

        // contention with burst limit 2: grants alternate 0,1,0,1
        base = line_q.size(); rd0_cnt = 0; rd1_cnt = 0;
        p0 = '{8'h50, 8'h51, 8'h52, 8'h53};
        p1 = '{8'h60, 8'h61, 8'h62, 8'h63};
        fork
            send_pkt(0, p0);
            send_pkt(1, p1);
        join
        idle_wait("t4");
        e = '{8'hB1, 8'h00, 8'h50, 8'h51, 8'hB1, 8'h01, 8'h60, 8'h61,
              8'hB1, 8'h00, 8'h52, 8'h53, 8'hB1, 8'h01, 8'h62, 8'h63};
        check_line("t4", base, e);
        check_val("t4 ready counts", 32'({rd0_cnt[7:0], rd1_cnt[7:0]}), 32'h0404);

        // payload byte equal to ESC gets stuffed
        base = line_q.size(); rd0_cnt = 0;
        p0 = '{8'hB1}; send_pkt(0, p0); idle_wait("t3");
        e = '{8'hB1, 8'h00, 8'hB1, 8'hB1}; check_line("t3", base, e);
        check_val("t3 ready0 count", 32'(rd0_cnt), 32'd1);

        // TX_READY low for 50 cycles mid-packet
        base = line_q.size(); bad_we = 0; bad_rd = 0; rise_cyc = 0;
        p0 = '{8'h70, 8'h71, 8'h72};
        fork
            send_pkt(0, p0);
            begin
                for (int k = 0; k < 200; k++) begin
                    @(negedge clk);
                    if (line_q.size() > base) break;
                end
                @(posedge clk); #1 tx_ready = 1'b0;
                repeat (50) @(posedge clk);
                #1 tx_ready = 1'b1; rise_cyc = cyc;
            end
        join
        idle_wait("t5");
        e = '{8'h70, 8'h71, 8'h72}; check_line("t5", base, e);
        check_val("t5 we while tx low", 32'(bad_we), 32'd0);
        check_val("t5 ready while tx low", 32'(bad_rd), 32'd0);
        if (we_cyc_q.size() >= base + 2)
            check_val("t5 resume after tx_ready", 32'(we_cyc_q[base + 1] > rise_cyc), 32'd1);

        // async reset while in SEND_CH
        base = line_q.size();
        valid1 = 1'b1; data1 = 8'h33; last1 = 1'b1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (line_q.size() > base) break;
        end
        check_val("t6 esc before reset", 32'(dsend), 32'hB1);
        #2 rst_n = 1'b0;
        #1;
        check_val("t6 async we", 32'(we), 32'd0);
        check_val("t6 async dsend", 32'(dsend), 32'd0);
        check_val("t6 async busy", 32'(busy), 32'd0);
        check_val("t6 async ready", 32'({ready0, ready1}), 32'd0);
        check_val("t6 async channel", 32'(channel), 32'd0);
        @(posedge clk); @(negedge clk);
        base = line_q.size();
        rst_n = 1'b1;
        p1 = '{8'h33}; send_pkt(1, p1); idle_wait("t6");
        e = '{8'hB1, 8'h01, 8'h33}; check_line("t6", base, e);

        check_val("both ready never", 32'(both_rd), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
